// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Holds the frame state encoding and the fixed line levels of a frame.
package uart_pkg;

  // Frame sequencing states, 2-bit encoding shared with the receiver
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Fixed line levels of a UART frame
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every bit period.
// Ports:
//   i_CLK   - system clock, rising edge
//   i_RST_N - asynchronous active-low reset
//   i_CLEAR - hold the counter at zero (line idle)
//   o_TICK  - high on the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_CLK,
  input  logic i_RST_N,
  input  logic i_CLEAR,
  output logic o_TICK
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps after the last cycle
  always_comb begin
    cnt_d = cnt_q;
    if (i_CLEAR) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_TICK = (cnt_q == CNT_LAST);

endmodule : uart_baud_tick

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte per frame as start bit (0),
// DATA_BITS data bits LSB first, stop bit (1). Bytes arrive over a
// valid/ready handshake; all outputs are registered.
// Ports:
//   i_CLK   - system clock, rising edge
//   i_RST_N - asynchronous active-low reset (aborts any frame)
//   i_DATA  - byte to send, latched on handshake only
//   i_VALID - source presents i_DATA
//   o_READY - transmitter can accept a byte (IDLE only)
//   o_TX    - serial line, idles high
//   o_BUSY  - frame in progress
//   o_DONE  - one-cycle pulse in the first IDLE cycle after a frame
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_N,
  input  logic [DATA_BITS-1:0] i_DATA,
  input  logic                 i_VALID,
  output logic                 o_READY,
  output logic                 o_TX,
  output logic                 o_BUSY,
  output logic                 o_DONE
);

  localparam int               IDX_W    = $clog2(DATA_BITS) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick_s;
  logic                 clear_s;

  // The bit timer only runs inside a frame, so every frame starts on a
  // fresh full-length bit period.
  assign clear_s = (state_q == UART_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_CLK  (i_CLK),
    .i_RST_N(i_RST_N),
    .i_CLEAR(clear_s),
    .o_TICK (tick_s)
  );

  // Next-state and next-output decode. Outputs are computed from the
  // upcoming state so the registered line changes on the same edge as
  // the state, keeping each bit exactly CLKS_PER_BIT cycles wide.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = UART_IDLE_LEVEL;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (i_VALID && ready_q) begin
          state_d = UART_START;
          shift_d = i_DATA;
          idx_d   = '0;
          tx_d    = UART_START_BIT;
        end else begin
          tx_d    = UART_IDLE_LEVEL;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      UART_START: begin
        if (tick_s) begin
          state_d = UART_DATA;
          tx_d    = shift_q[0];
        end else begin
          tx_d    = UART_START_BIT;
        end
      end
      UART_DATA: begin
        if (tick_s) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = UART_STOP;
            idx_d   = '0;
            tx_d    = UART_STOP_BIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            // Next bit is already visible at shift_q[1] before the shift lands
            tx_d    = shift_q[1];
          end
        end else begin
          tx_d    = shift_q[0];
        end
      end
      UART_STOP: begin
        tx_d = UART_STOP_BIT;
        if (tick_s) begin
          state_d = UART_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = UART_IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= UART_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_TX    = tx_q;
  assign o_READY = ready_q;
  assign o_BUSY  = busy_q;
  assign o_DONE  = done_q;

endmodule : uart_transmitter
